// File: rtl/alu_exec_ctrl.sv
// ALU control decode plus registered execute stage with valid/ready handshake.
// MUL runs on an iterative shift-add engine: one multiplier bit per cycle.
module alu_exec_ctrl #(
    parameter int unsigned WIDTH  = 32,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       aluop,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);
    localparam int unsigned SH_W = $clog2(WIDTH);

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010, OP_XOR  = 4'b0011,
        OP_SLL  = 4'b0100, OP_SRL = 4'b0101, OP_SUB = 4'b0110, OP_SRA  = 4'b0111,
        OP_SLT  = 4'b1000, OP_SLTU = 4'b1001, OP_MUL = 4'b1010
    } alu_op_e;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FULL} state_e;

    state_e             r_state, w_state_next;
    alu_op_e            w_op;
    logic               w_illegal, w_is_mul, w_accept, w_last;
    logic [WIDTH-1:0]   w_res, w_acc_next;
    logic [SH_W-1:0]    w_shamt;
    logic [WIDTH-1:0]   r_result, r_mcand, r_mplier, r_acc;
    logic [3:0]         r_alu_op;
    logic               r_zero, r_illegal;
    logic [SH_W-1:0]    r_cnt;

    function automatic alu_op_e f3_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return OP_ADD;
            3'b001:  return OP_SLL;
            3'b010:  return OP_SLT;
            3'b011:  return OP_SLTU;
            3'b100:  return OP_XOR;
            3'b101:  return OP_SRL;
            3'b110:  return OP_OR;
            default: return OP_AND;
        endcase
    endfunction

    always_comb begin
        w_op      = OP_ADD;
        w_illegal = 1'b0;
        w_is_mul  = 1'b0;
        case (aluop)
            2'b00: w_op = OP_ADD;
            2'b01: w_op = OP_SUB;
            2'b10: begin
                if (funct7 == 7'b0000000) begin
                    w_op = f3_op(funct3);
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    w_op = OP_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    w_op = OP_SRA;
                end else if (funct7 == 7'b0000001 && funct3 == 3'b000 && MUL_EN) begin
                    w_op     = OP_MUL;
                    w_is_mul = 1'b1;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            default: begin
                if (funct3 == 3'b001) begin
                    if (funct7 == 7'b0000000) w_op = OP_SLL;
                    else                      w_illegal = 1'b1;
                end else if (funct3 == 3'b101) begin
                    // Only funct7[5] may be set: it selects arithmetic shift.
                    if ((funct7 & 7'b1011111) == 7'b0000000) w_op = funct7[5] ? OP_SRA : OP_SRL;
                    else                                     w_illegal = 1'b1;
                end else begin
                    w_op = f3_op(funct3);
                end
            end
        endcase
    end

    assign w_shamt = b[SH_W-1:0];

    always_comb begin
        w_res = '0;
        case (w_op)
            OP_AND:  w_res = a & b;
            OP_OR:   w_res = a | b;
            OP_ADD:  w_res = a + b;
            OP_XOR:  w_res = a ^ b;
            OP_SLL:  w_res = a << w_shamt;
            OP_SRL:  w_res = a >> w_shamt;
            OP_SUB:  w_res = a - b;
            OP_SRA:  w_res = WIDTH'($signed(a) >>> w_shamt);
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: w_res = '0;
        endcase
        if (w_illegal) w_res = '0;
    end

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_last     = (r_cnt == SH_W'(WIDTH - 1));
    assign w_accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = !reset;
                if (in_valid && !reset) w_state_next = w_is_mul ? S_BUSY : S_FULL;
            end
            S_BUSY: begin
                if (w_last) w_state_next = S_FULL;
            end
            default: begin
                out_valid = 1'b1;
                in_ready  = out_ready && !reset;
                if (out_ready) w_state_next = in_valid ? (w_is_mul ? S_BUSY : S_FULL) : S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_result  <= '0;
            r_alu_op  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
        end else if (w_accept) begin
            r_alu_op  <= w_op;
            r_illegal <= w_illegal;
            if (w_is_mul) begin
                r_mcand  <= a;
                r_mplier <= b;
                r_acc    <= '0;
                r_cnt    <= '0;
            end else begin
                r_result <= w_res;
                r_zero   <= (w_res == '0);
            end
        end else if (r_state == S_BUSY) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                r_result <= w_acc_next;
                r_zero   <= (w_acc_next == '0);
            end
        end
    end

    assign result  = r_result;
    assign alu_op  = r_alu_op;
    assign zero    = r_zero;
    assign illegal = r_illegal;
endmodule
